sw_debounce_in_port: RTL and testbench
======================================

// Module: sw_debounce_in_port
// PURPOSE
//  Input-side counterpart of the seven-segment/LED output path: turns raw slide-switch/DIP pins into a
//  clean 32-bit CPU input port. Per bit: 2-FF synchronizer, then a counter-based debouncer.
//  Stable value is zero-extended onto in_port for sc_computer_main in_port0/in_port1.
//  A sticky change flag plus read-acknowledge handshake lets software poll for new input.
// PARAMETERS
//  WIDTH            5          number of raw input pins (1..32)
//  SYNC_STAGES      2          synchronizer flops per bit (>=2)
//  DEBOUNCE_CYCLES  1000000    cycles a synced level must hold before acceptance (10 ms @ 100 MHz; >=2)
//  CNT_W            20         debounce counter width, must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  sys_clk_in    in   1      100 MHz system clock, all logic on rising edge
//  sys_rst_n     in   1      asynchronous, active-low reset
//  raw_pin       in   WIDTH  asynchronous switch pins
//  rd_ack        in   1      1-cycle pulse: CPU has read in_port, clears changed
//  in_port       out  32     {(32-WIDTH)'b0, debounced[WIDTH-1:0]}
//  change_pulse  out  1      1-cycle pulse in the cycle after any debounced bit updates
//  changed       out  1      sticky: set by change_pulse condition, cleared by rd_ack
// BEHAVIOUR
//  - Reset (async assert, sync release): sync flops, debounced, counters, change_pulse, changed all 0;
//    in_port = 0. A pin already high at reset is reported as a normal change after debounce.
//  - Sync: sync[b] = raw_pin[b] delayed SYNC_STAGES cycles. No logic reads earlier stages.
//  - Debounce, per bit, independent counter cnt[b]:
//      sync[b] == debounced[b]           -> cnt[b] <= 0
//      differ, cnt[b] <  DEBOUNCE_CYCLES-1 -> cnt[b] <= cnt[b]+1
//      differ, cnt[b] == DEBOUNCE_CYCLES-1 -> debounced[b] <= sync[b], cnt[b] <= 0
//    Any return to the old level restarts the count (no partial credit; counter never wraps).
//  - Latency: pin change held steady -> in_port updates exactly SYNC_STAGES+DEBOUNCE_CYCLES edges later.
//    A pulse shorter than DEBOUNCE_CYCLES synced cycles never reaches in_port.
//  - change_pulse: registered; high for exactly 1 cycle, the cycle after debounced changes. Bits
//    updating on the same edge give ONE pulse. Updates on consecutive edges give back-to-back pulses.
//  - changed: set when the change_pulse condition is true, cleared when rd_ack=1.
//    Set and rd_ack in the same cycle -> set wins (changed stays 1, no lost event).
//    rd_ack while changed=0 is a no-op.
//  - in_port is a direct register output, glitch-free. Upper 32-WIDTH bits are constant 0.
//  - Reset mid-debounce discards all progress. After release the bit needs a full DEBOUNCE_CYCLES again.
// STRUCTURE
//  - Shared package io_pkg: IO_PORT_W=32, SYS_CLK_HZ=100_000_000, DEBOUNCE_MS default,
//    and a function computing DEBOUNCE_CYCLES from clock rate and ms. Reused by display/LED blocks.
//  - Sub-module in_bit_debounce (SYNC_STAGES, DEBOUNCE_CYCLES, CNT_W): one bit, with ports
//    clk, rst_n, raw, level, toggled. Generated WIDTH times.
//  - Top: OR-reduce toggled into change_pulse / changed, zero-extend into in_port.
//  - Two instances replace the combinational in_port zero-extenders for sw_pin and dip_pin.
// TESTING (bench: WIDTH=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//  1 Reset with raw_pin=5'b00000, run 20 cycles -> in_port=0, change_pulse never 1, changed=0.
//  2 raw_pin 0->5'b10101 at edge 0 and held -> in_port=32'h15 at edge 6, single change_pulse at
//    edge 7, changed=1 from edge 7.
//  3 Bit0 glitch high for 3 cycles, then low -> in_port unchanged, no pulse. Glitch 4+ cycles -> accepted.
//  4 changed=1, rd_ack pulse -> changed=0 next cycle. Then rd_ack coincident with a new update
//    -> changed remains 1.
//  5 Bit0 and bit4 toggled on the same edge -> one change_pulse.
//    Bit4 toggled 1 cycle after bit0 -> two consecutive pulses.
//  6 Assert sys_rst_n low mid-count (cnt=2, no clock edge) -> outputs 0 immediately.
//    Release with raw held -> acceptance takes full 6 cycles again.

Source files
------------

// File: rtl/sw_debounce_in_port_pkg.sv
// Shared I/O constants and the helper that converts a debounce time into clock cycles.
package sw_debounce_in_port_pkg;

    localparam int unsigned IO_PORT_W   = 32;
    localparam int unsigned SYS_CLK_HZ  = 100_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;

    // Cycles needed to cover 'ms' milliseconds at 'clk_hz'.
    function automatic int unsigned debounce_cycles(input int unsigned clk_hz,
                                                    input int unsigned ms);
        return (clk_hz / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/sw_debounce_in_port_if.sv
// CPU-facing input port bundle: raw pins and read-ack in, debounced port and change flags out.
interface sw_debounce_in_port_if #(
    parameter int unsigned WIDTH = 5
);
    import sw_debounce_in_port_pkg::*;

    logic [WIDTH-1:0]     raw_pin;
    logic                 rd_ack;
    logic [IO_PORT_W-1:0] in_port;
    logic                 change_pulse;
    logic                 changed;

    modport master (
        output raw_pin, rd_ack,
        input  in_port, change_pulse, changed
    );

    modport slave (
        input  raw_pin, rd_ack,
        output in_port, change_pulse, changed
    );
endinterface

// File: rtl/sw_debounce_in_port_in_bit_debounce.sv
// One input bit: synchronizer chain followed by a hold-time counter debouncer.
module in_bit_debounce
    import sw_debounce_in_port_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = debounce_cycles(SYS_CLK_HZ, DEBOUNCE_MS),
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic toggled
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   toggled_q, toggled_d;
    logic                   sync;

    // Only the last synchronizer stage is safe to observe.
    assign sync = sync_q[SYNC_STAGES-1];

    // Next-state: count while the synced level differs, accept on the final count, restart otherwise.
    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        toggled_d = 1'b0;
        if (sync != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d   = sync;
                toggled_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer shift, debounce counter and accepted level; reset discards any progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            toggled_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            toggled_q <= toggled_d;
        end
    end

    assign level   = level_q;
    assign toggled = toggled_q;
endmodule

// File: rtl/sw_debounce_in_port.sv
// Debounced switch input port: WIDTH independent bit debouncers, zero-extended to the CPU port,
// with a one-cycle change pulse and a sticky changed flag cleared by a read acknowledge.
module sw_debounce_in_port
    import sw_debounce_in_port_pkg::*;
#(
    parameter int unsigned WIDTH           = 5,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = debounce_cycles(SYS_CLK_HZ, DEBOUNCE_MS),
    parameter int unsigned CNT_W           = 20
) (
    input  logic                  sys_clk_in,
    input  logic                  sys_rst_n,
    sw_debounce_in_port_if.slave  bus
);
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] toggled;
    logic             any_toggle;
    logic             change_pulse_q, change_pulse_d;
    logic             changed_q, changed_d;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        in_bit_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk    (sys_clk_in),
            .rst_n  (sys_rst_n),
            .raw    (bus.raw_pin[b]),
            .level  (level[b]),
            .toggled(toggled[b])
        );
    end

    // Bits accepted on the same edge collapse into a single event.
    assign any_toggle = |toggled;

    // A new event outranks a coincident read ack so no change is lost.
    always_comb begin
        change_pulse_d = any_toggle;
        changed_d      = changed_q;
        if (any_toggle)
            changed_d = 1'b1;
        else if (bus.rd_ack)
            changed_d = 1'b0;
    end

    // Event flags are registered so both outputs come straight from flops.
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            change_pulse_q <= 1'b0;
            changed_q      <= 1'b0;
        end else begin
            change_pulse_q <= change_pulse_d;
            changed_q      <= changed_d;
        end
    end

    // Level bits are flop outputs; the upper port bits are tied low.
    assign bus.in_port      = IO_PORT_W'(level);
    assign bus.change_pulse = change_pulse_q;
    assign bus.changed      = changed_q;
endmodule

// File: tb/tb_sw_debounce_in_port.sv
// Directed bench for the debounced input port (WIDTH=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_sw_debounce_in_port;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sw_debounce_in_port_if #(.WIDTH(5)) bus ();

    sw_debounce_in_port #(
        .WIDTH          (5),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .sys_clk_in(clk),
        .sys_rst_n (rst_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.raw_pin = 5'b00000;
        bus.rd_ack  = 1'b0;
        #1;
        if (bus.in_port !== 32'h0) begin errors++; $display("FAIL reset in_port got %h exp %h", bus.in_port, 32'h0); end
        checks++;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.change_pulse !== 1'b0) begin errors++; $display("FAIL reset pulse k=%0d got %b exp 0", k, bus.change_pulse); end
            checks++;
        end
        if (bus.in_port !== 32'h0) begin errors++; $display("FAIL reset idle in_port got %h exp 0", bus.in_port); end
        if (bus.changed !== 1'b0) begin errors++; $display("FAIL reset changed got %b exp 0", bus.changed); end
        checks += 2;
    endtask

    task automatic test_accept();
        bus.raw_pin = 5'b10101;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus.in_port !== ((k >= 6) ? 32'h15 : 32'h0)) begin errors++; $display("FAIL accept in_port k=%0d got %h", k, bus.in_port); end
            if (bus.change_pulse !== (k == 7)) begin errors++; $display("FAIL accept pulse k=%0d got %b exp %b", k, bus.change_pulse, k == 7); end
            if (bus.changed !== (k >= 7)) begin errors++; $display("FAIL accept changed k=%0d got %b exp %b", k, bus.changed, k >= 7); end
            checks += 3;
        end
    endtask

    task automatic test_rd_ack();
        // changed is 1 here; a new update coincident with rd_ack must keep it set.
        bus.raw_pin = 5'b10100;
        for (int k = 1; k <= 6; k++) tick();
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        if (bus.change_pulse !== 1'b1) begin errors++; $display("FAIL ack_coincide pulse got %b exp 1", bus.change_pulse); end
        if (bus.changed !== 1'b1) begin errors++; $display("FAIL ack_coincide changed got %b exp 1", bus.changed); end
        if (bus.in_port !== 32'h14) begin errors++; $display("FAIL ack_coincide in_port got %h exp 14", bus.in_port); end
        checks += 3;
        tick();
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        if (bus.changed !== 1'b0) begin errors++; $display("FAIL ack_clear changed got %b exp 0", bus.changed); end
        checks++;
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        if (bus.changed !== 1'b0) begin errors++; $display("FAIL ack_noop changed got %b exp 0", bus.changed); end
        checks++;
    endtask

    task automatic test_glitch();
        // 3 synced cycles high: rejected.
        bus.raw_pin = 5'b10101;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) bus.raw_pin = 5'b10100;
            tick();
            if (bus.in_port !== 32'h14) begin errors++; $display("FAIL glitch3 in_port k=%0d got %h exp 14", k, bus.in_port); end
            if (bus.change_pulse !== 1'b0) begin errors++; $display("FAIL glitch3 pulse k=%0d got %b exp 0", k, bus.change_pulse); end
            checks += 2;
        end
        // 4 synced cycles high: accepted, then the return to low is accepted too.
        bus.raw_pin = 5'b10101;
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) bus.raw_pin = 5'b10100;
            tick();
            if (bus.in_port !== ((k >= 6 && k <= 9) ? 32'h15 : 32'h14)) begin errors++; $display("FAIL glitch4 in_port k=%0d got %h", k, bus.in_port); end
            if (bus.change_pulse !== (k == 7 || k == 11)) begin errors++; $display("FAIL glitch4 pulse k=%0d got %b", k, bus.change_pulse); end
            checks += 2;
        end
    endtask

    task automatic test_same_edge();
        bus.raw_pin = 5'b00101;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (bus.in_port !== ((k >= 6) ? 32'h05 : 32'h14)) begin errors++; $display("FAIL same_edge in_port k=%0d got %h", k, bus.in_port); end
            if (bus.change_pulse !== (k == 7)) begin errors++; $display("FAIL same_edge pulse k=%0d got %b", k, bus.change_pulse); end
            checks += 2;
        end
    endtask

    task automatic test_back_to_back();
        bus.raw_pin = 5'b00100;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) bus.raw_pin = 5'b10100;
            if (bus.in_port !== ((k >= 7) ? 32'h14 : (k == 6) ? 32'h04 : 32'h05)) begin errors++; $display("FAIL b2b in_port k=%0d got %h", k, bus.in_port); end
            if (bus.change_pulse !== (k == 7 || k == 8)) begin errors++; $display("FAIL b2b pulse k=%0d got %b", k, bus.change_pulse); end
            checks += 2;
        end
    endtask

    task automatic test_reset_mid();
        bus.raw_pin = 5'b10110;
        for (int k = 1; k <= 4; k++) tick();
        rst_n = 1'b0;
        #1;
        if (bus.in_port !== 32'h0) begin errors++; $display("FAIL rst_mid in_port got %h exp 0", bus.in_port); end
        if (bus.changed !== 1'b0) begin errors++; $display("FAIL rst_mid changed got %b exp 0", bus.changed); end
        if (bus.change_pulse !== 1'b0) begin errors++; $display("FAIL rst_mid pulse got %b exp 0", bus.change_pulse); end
        checks += 3;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus.in_port !== ((k >= 6) ? 32'h16 : 32'h0)) begin errors++; $display("FAIL rst_mid accept in_port k=%0d got %h", k, bus.in_port); end
            if (bus.change_pulse !== (k == 7)) begin errors++; $display("FAIL rst_mid accept pulse k=%0d got %b", k, bus.change_pulse); end
            checks += 2;
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_rd_ack();
        test_glitch();
        test_same_edge();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
